muxi: RTL and testbench

- Registered N-to-1 lane multiplexer.
- Selects one DATA_W-bit lane from a packed input bus using a binary select and presents it on a registered output one clock later.
- Default configuration is an 8:1 single-bit mux, used as a generic select/steering element in datapaths.
- Includes a valid qualifier and out-of-range select detection.

---
 rtl/muxi_pkg.sv | 24 ++
 rtl/muxi_decode.sv | 30 +++
 rtl/muxi.sv | 101 ++++++++++
 tb/tb_muxi.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/muxi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muxi_pkg
// Description : Shared constants and the select-width helper for the muxi
//               registered lane multiplexer.
//               MUXI_N_IN_DEF   - default number of input lanes
//               MUXI_DATA_W_DEF - default lane width in bits
//               muxi_sel_w()    - select width for a given lane count,
//                                 max(1, ceil(log2(n_in)))
// Revision    : 1.0 - initial release
// ============================================================================
package muxi_pkg;

  localparam int MUXI_N_IN_DEF   = 8;
  localparam int MUXI_DATA_W_DEF = 1;

  // A 2-lane or degenerate mux still needs one select bit; $clog2 alone
  // would return 0 for n_in = 1.
  function automatic int muxi_sel_w(input int n_in);
    return (n_in <= 2) ? 1 : $clog2(n_in);
  endfunction

endpackage : muxi_pkg
`default_nettype wire

// File: rtl/muxi_decode.sv
`default_nettype none
// ============================================================================
// Module      : muxi_decode
// Description : Combinational binary-to-one-hot select decoder with range
//               check.
// Ports       : sel      [SEL_W-1:0] in  - binary lane index
//               onehot   [N_IN-1:0]  out - bit k set when sel == k
//               in_range             out - high when sel < N_IN
// Revision    : 1.0 - initial release
// ============================================================================
module muxi_decode
  import muxi_pkg::*;
#(
  parameter int N_IN  = MUXI_N_IN_DEF,
  parameter int SEL_W = muxi_sel_w(N_IN)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_IN-1:0]  onehot,
  output logic             in_range
);

  // Compared at 32 bits so N_IN = 2**SEL_W (e.g. 256) needs no special case.
  for (genvar k = 0; k < N_IN; k++) begin : g_onehot
    assign onehot[k] = (32'(sel) == 32'(k));
  end

  assign in_range = (32'(sel) < 32'(N_IN));

endmodule : muxi_decode
`default_nettype wire

// File: rtl/muxi.sv
`default_nettype none
// ============================================================================
// Module      : muxi
// Description : Registered N-to-1 lane multiplexer with valid qualifier and
//               out-of-range select detection. One cycle of latency.
//               Optional feature macro: MUXI_ONEHOT_SEL_EN adds a registered
//               one-hot copy of the accepted select (sel_onehot_o).
// Ports       : clk                        in  - rising-edge clock
//               rst_n                      in  - async active-low reset
//               data    [N_IN*DATA_W-1:0]  in  - packed lanes, lane 0 at LSBs
//               sel     [SEL_W-1:0]        in  - binary lane index
//               valid_i                    in  - qualifies data/sel
//               data_o  [DATA_W-1:0]       out - selected lane (registered)
//               valid_o                    out - data_o updated this cycle
//               sel_err_o                  out - last accepted sel >= N_IN
//               sel_onehot_o [N_IN-1:0]    out - (MUXI_ONEHOT_SEL_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module muxi
  import muxi_pkg::*;
#(
  parameter int N_IN   = MUXI_N_IN_DEF,
  parameter int DATA_W = MUXI_DATA_W_DEF,
  parameter int SEL_W  = muxi_sel_w(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   valid_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   valid_o,
  output logic                   sel_err_o
`ifdef MUXI_ONEHOT_SEL_EN
  ,
  output logic [N_IN-1:0]        sel_onehot_o
`endif
);

  logic [N_IN-1:0]   w_onehot;
  logic              w_in_range;
  logic [DATA_W-1:0] w_sel_data;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_sel_err;

  muxi_decode #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_decode (
    .sel      (sel),
    .onehot   (w_onehot),
    .in_range (w_in_range)
  );

  // AND-OR lane select. An out-of-range sel yields an all-zero one-hot,
  // which makes the selected value 0 without a separate override.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_sel_data = w_sel_data | (data[k*DATA_W +: DATA_W] & {DATA_W{w_onehot[k]}});
    end
  end

  // valid_o tracks valid_i every cycle; data and error flag only move on an
  // accepted (valid) cycle and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_data    <= w_sel_data;
        r_sel_err <= ~w_in_range;
      end
    end
  end

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign sel_err_o = r_sel_err;

`ifdef MUXI_ONEHOT_SEL_EN
  logic [N_IN-1:0] r_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onehot <= '0;
    end else if (valid_i) begin
      r_onehot <= w_onehot;
    end
  end

  assign sel_onehot_o = r_onehot;
`endif

endmodule : muxi
`default_nettype wire

// File: tb/tb_muxi.sv
`default_nettype none
// ============================================================================
// Module      : tb_muxi
// Description : Directed self-checking bench for muxi. Drives a default
//               8x1 instance and a 5x4 instance (non-power-of-two lane count
//               for select range errors). Honours MUXI_ONEHOT_SEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muxi;

  logic clk;
  logic rst_n;

  // default 8:1 x 1-bit instance
  logic [7:0] data8;
  logic [2:0] sel8;
  logic       valid8;
  logic [0:0] data_o8;
  logic       valid_o8;
  logic       err_o8;

  // 5:1 x 4-bit instance
  logic [19:0] data5;
  logic [2:0]  sel5;
  logic        valid5;
  logic [3:0]  data_o5;
  logic        valid_o5;
  logic        err_o5;

`ifdef MUXI_ONEHOT_SEL_EN
  logic [7:0] onehot_o8;
  logic [4:0] onehot_o5;
`endif

  int n_checks;
  int n_errors;

  muxi u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data8),
    .sel       (sel8),
    .valid_i   (valid8),
    .data_o    (data_o8),
    .valid_o   (valid_o8),
    .sel_err_o (err_o8)
`ifdef MUXI_ONEHOT_SEL_EN
    ,
    .sel_onehot_o (onehot_o8)
`endif
  );

  muxi #(
    .N_IN   (5),
    .DATA_W (4)
  ) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data5),
    .sel       (sel5),
    .valid_i   (valid5),
    .data_o    (data_o5),
    .valid_o   (valid_o5),
    .sel_err_o (err_o5)
`ifdef MUXI_ONEHOT_SEL_EN
    ,
    .sel_onehot_o (onehot_o5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] exp_sweep;
    n_checks = 0;
    n_errors = 0;

    rst_n  = 1'b0;
    data8  = '0; sel8 = '0; valid8 = 1'b0;
    data5  = '0; sel5 = '0; valid5 = 1'b0;
    step(); step();

    chk("rst_data8",  32'(data_o8),  32'd0);
    chk("rst_valid8", 32'(valid_o8), 32'd0);
    chk("rst_err8",   32'(err_o8),   32'd0);
    chk("rst_data5",  32'(data_o5),  32'd0);

    rst_n = 1'b1;
    step();

    // Sweep lane select on a mixed pattern.
    pat       = 8'b1001_1010;
    exp_sweep = 8'b1001_1010;  // lane k of the pattern is bit k
    data8  = pat;
    valid8 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      step();
      chk($sformatf("sweep_data_s%0d", s), 32'(data_o8), 32'(exp_sweep[s]));
      chk($sformatf("sweep_valid_s%0d", s), 32'(valid_o8), 32'd1);
    end
    chk("sweep_err", 32'(err_o8), 32'd0);

    // All-zero then all-one data.
    data8 = 8'h00;
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      step();
      chk($sformatf("zero_s%0d", s), 32'(data_o8), 32'd0);
    end
    data8 = 8'hFF;
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      step();
      chk($sformatf("ones_s%0d", s), 32'(data_o8), 32'd1);
    end

    // Hold: outputs freeze while valid_i is low.
    data8 = 8'b1001_1010;
    sel8  = 3'd3;
    step();
    chk("hold_pre_data", 32'(data_o8), 32'd1);
    valid8 = 1'b0;
    sel8   = 3'd0;
    step();
    chk("hold_data",  32'(data_o8),  32'd1);
    chk("hold_valid", 32'(valid_o8), 32'd0);
    data8 = 8'h00;
    step();
    chk("hold_data2", 32'(data_o8), 32'd1);

`ifdef MUXI_ONEHOT_SEL_EN
    valid8 = 1'b1;
    sel8   = 3'd5;
    step();
    chk("onehot8_s5", 32'(onehot_o8), 32'h20);
    valid8 = 1'b0;
    sel8   = 3'd1;
    step();
    chk("onehot8_hold", 32'(onehot_o8), 32'h20);
`endif

    // Range errors on the 5-lane instance.
    data5  = 20'hABCDE;
    valid5 = 1'b1;
    sel5   = 3'd4;
    step();
    chk("r5_s4_data", 32'(data_o5), 32'hA);
    chk("r5_s4_err",  32'(err_o5),  32'd0);
    sel5 = 3'd6;
    step();
    chk("r5_s6_data",  32'(data_o5),  32'h0);
    chk("r5_s6_err",   32'(err_o5),   32'd1);
    chk("r5_s6_valid", 32'(valid_o5), 32'd1);
`ifdef MUXI_ONEHOT_SEL_EN
    chk("r5_s6_onehot", 32'(onehot_o5), 32'h0);
`endif
    sel5 = 3'd5;
    step();
    chk("r5_s5_err", 32'(err_o5), 32'd1);
    valid5 = 1'b0;
    sel5   = 3'd0;
    step();
    chk("r5_hold_err",   32'(err_o5),   32'd1);
    chk("r5_hold_valid", 32'(valid_o5), 32'd0);
    valid5 = 1'b1;
    step();
    chk("r5_s0_data", 32'(data_o5), 32'hE);
    chk("r5_s0_err",  32'(err_o5),  32'd0);
    sel5 = 3'd2;
    step();
    chk("r5_s2_data", 32'(data_o5), 32'hC);
`ifdef MUXI_ONEHOT_SEL_EN
    chk("r5_s2_onehot", 32'(onehot_o5), 32'h04);
`endif

    // Asynchronous reset mid-stream, away from any clock edge.
    data8  = 8'hFF;
    sel8   = 3'd7;
    valid8 = 1'b1;
    sel5   = 3'd7;
    step();
    chk("pre_rst_data8", 32'(data_o8), 32'd1);
    chk("pre_rst_err5",  32'(err_o5),  32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data8",  32'(data_o8),  32'd0);
    chk("arst_valid8", 32'(valid_o8), 32'd0);
    chk("arst_err8",   32'(err_o8),   32'd0);
    chk("arst_err5",   32'(err_o5),   32'd0);
    chk("arst_valid5", 32'(valid_o5), 32'd0);
    step();
    chk("arst_hold_data8", 32'(data_o8), 32'd0);
    rst_n = 1'b1;
    sel5  = 3'd1;
    step();
    chk("post_rst_data8",  32'(data_o8),  32'd1);
    chk("post_rst_valid8", 32'(valid_o8), 32'd1);
    chk("post_rst_data5",  32'(data_o5),  32'hD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_muxi
`default_nettype wire
